// File: rtl/bolme_birimi.sv
// Iterative RV32M restoring divider (DIV/DIVU/REM/REMU) plus its CLA adder.
// Define BOLME_ERKEN_BITIS_EN to skip the loop when |dividend| < |divisor|.

module carry_lookahead_toplayici #(
    parameter int BIT = 32
) (
    input  logic [BIT-1:0] deger1_i,
    input  logic [BIT-1:0] deger2_i,
    input  logic           elde_i,
    output logic [BIT-1:0] toplam_o,
    output logic           elde_o
);

    localparam int GRUP = BIT / 4;

    logic [BIT-1:0]  p;
    logic [BIT-1:0]  g;
    logic [BIT:0]    c;
    logic [GRUP-1:0] gg;
    logic [GRUP-1:0] gp;
    logic [GRUP:0]   gc;

    assign p = deger1_i ^ deger2_i;
    assign g = deger1_i & deger2_i;

    // 4-bit groups: lookahead between groups, short ripple inside a group
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = elde_i;
        for (int j = 0; j < GRUP; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < GRUP; j++) begin
            c[4*j] = gc[j];
            for (int k = 0; k < 3; k++) begin
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
            end
        end
        c[BIT] = gc[GRUP];
    end

    assign toplam_o = p ^ c[BIT-1:0];
    assign elde_o   = c[BIT];

endmodule

module bolme_birimi #(
    parameter int BIT  = 32,
    parameter int ADIM = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           basla_i,
    input  logic [1:0]     islem_i,
    input  logic [BIT-1:0] deger1_i,
    input  logic [BIT-1:0] deger2_i,
    output logic [BIT-1:0] sonuc_o,
    output logic           gecerli_o,
    output logic           mesgul_o
);

    localparam int SW = $clog2(ADIM);
    localparam logic [SW-1:0] SON = SW'(ADIM - 1);
    localparam logic [SW-1:0] BIR = SW'(1);
    localparam logic [BIT-1:0] ARTI = BIT'(1);

    typedef enum logic [2:0] {
        BOSTA,
        HAZIRLA,
        HESAPLA,
        DUZELT,
        BITTI
    } durum_t;

    durum_t          durum;
    logic [1:0]      islem_r;
    logic [BIT-1:0]  deger1_r;
    logic [BIT-1:0]  deger2_r;
    logic [BIT-1:0]  bolum;
    logic [BIT-1:0]  kalan;
    logic [BIT-1:0]  bolen;
    logic [SW-1:0]   sayac;
    logic            isaret1;
    logic            isaret2;

    logic            isaretli;
    logic            kalan_islem;
    logic [BIT-1:0]  mutlak1;
    logic [BIT-1:0]  mutlak2;
    logic [BIT-1:0]  kalan_k;
    logic            ust;
    logic            sigar;
    logic            duzelt_neg;
    logic [BIT-1:0]  duzelt_x;

    logic [BIT-1:0]  top_a;
    logic [BIT-1:0]  top_b;
    logic            top_cin;
    logic [BIT-1:0]  toplam;
    logic            elde;

    assign isaretli    = ~islem_r[0];
    assign kalan_islem = islem_r[1];

    assign mutlak1 = (isaretli & deger1_r[BIT-1]) ? (~deger1_r + ARTI) : deger1_r;
    assign mutlak2 = (isaretli & deger2_r[BIT-1]) ? (~deger2_r + ARTI) : deger2_r;

    assign kalan_k = {kalan[BIT-2:0], bolum[BIT-1]};
    assign ust     = kalan[BIT-1];
    // the shifted-out bit extends the partial remainder to 33 bits
    assign sigar   = ust | elde;

    assign duzelt_neg = isaretli & (kalan_islem ? isaret1 : (isaret1 ^ isaret2));
    assign duzelt_x   = kalan_islem ? kalan : bolum;

    always_comb begin
        top_a   = '0;
        top_b   = '0;
        top_cin = 1'b0;
        case (durum)
            HESAPLA: begin
                top_a   = kalan_k;
                top_b   = ~bolen;
                top_cin = 1'b1;
            end
            DUZELT: begin
                top_a   = ~duzelt_x;
                top_b   = '0;
                top_cin = 1'b1;
            end
            default: begin
                top_a   = '0;
                top_b   = '0;
                top_cin = 1'b0;
            end
        endcase
    end

    carry_lookahead_toplayici #(
        .BIT (BIT)
    ) u_toplayici (
        .deger1_i (top_a),
        .deger2_i (top_b),
        .elde_i   (top_cin),
        .toplam_o (toplam),
        .elde_o   (elde)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum     <= BOSTA;
            islem_r   <= '0;
            deger1_r  <= '0;
            deger2_r  <= '0;
            bolum     <= '0;
            kalan     <= '0;
            bolen     <= '0;
            sayac     <= '0;
            isaret1   <= 1'b0;
            isaret2   <= 1'b0;
            sonuc_o   <= '0;
            gecerli_o <= 1'b0;
            mesgul_o  <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (basla_i) begin
                        islem_r  <= islem_i;
                        deger1_r <= deger1_i;
                        deger2_r <= deger2_i;
                        mesgul_o <= 1'b1;
                        durum    <= HAZIRLA;
                    end
                end
                HAZIRLA: begin
                    isaret1 <= isaretli & deger1_r[BIT-1];
                    isaret2 <= isaretli & deger2_r[BIT-1];
                    bolum   <= mutlak1;
                    bolen   <= mutlak2;
                    kalan   <= '0;
                    sayac   <= '0;
                    if (mutlak2 == '0) begin
                        sonuc_o   <= kalan_islem ? deger1_r : '1;
                        gecerli_o <= 1'b1;
                        durum     <= BITTI;
                    end
`ifdef BOLME_ERKEN_BITIS_EN
                    else if (mutlak1 < mutlak2) begin
                        bolum <= '0;
                        kalan <= mutlak1;
                        durum <= DUZELT;
                    end
`endif
                    else begin
                        durum <= HESAPLA;
                    end
                end
                HESAPLA: begin
                    bolum <= {bolum[BIT-2:0], sigar};
                    kalan <= sigar ? toplam : kalan_k;
                    sayac <= sayac + BIR;
                    if (sayac == SON) begin
                        durum <= DUZELT;
                    end
                end
                DUZELT: begin
                    sonuc_o   <= duzelt_neg ? toplam : duzelt_x;
                    gecerli_o <= 1'b1;
                    durum     <= BITTI;
                end
                BITTI: begin
                    gecerli_o <= 1'b0;
                    mesgul_o  <= 1'b0;
                    durum     <= BOSTA;
                end
                default: begin
                    gecerli_o <= 1'b0;
                    mesgul_o  <= 1'b0;
                    durum     <= BOSTA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bolme_birimi.sv
// Bench for bolme_birimi: vector table, reset/back-to-back sequences,
// and random ops against an arithmetic reference model.

module tb_bolme_birimi;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        basla_i = 1'b0;
    logic [1:0]  islem_i = 2'b00;
    logic [31:0] deger1_i = '0;
    logic [31:0] deger2_i = '0;
    logic [31:0] sonuc_o;
    logic        gecerli_o;
    logic        mesgul_o;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BOLME_ERKEN_BITIS_EN
    localparam bit ERKEN = 1'b1;
`else
    localparam bit ERKEN = 1'b0;
`endif
    localparam int LAT_E = ERKEN ? 3 : 35;

    always #5 clk_i = ~clk_i;

    bolme_birimi dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .basla_i   (basla_i),
        .islem_i   (islem_i),
        .deger1_i  (deger1_i),
        .deger2_i  (deger2_i),
        .sonuc_o   (sonuc_o),
        .gecerli_o (gecerli_o),
        .mesgul_o  (mesgul_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vek_t;

    vek_t vek[17];

    task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", ad, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        if (b == 0) return 2;
        if (ERKEN && ma < mb) return 3;
        return 35;
    endfunction

    // one op: accept, scramble inputs, time the pulse, check pulse ends
    task automatic do_op(input string ad, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat);
        int lat;
        logic [31:0] r;
        int w;
        w = 0;
        @(negedge clk_i);
        while (mesgul_o && w < 60) begin
            @(negedge clk_i);
            w++;
        end
        chk({ad, " idle"}, {31'b0, mesgul_o}, 32'd0);
        islem_i  = op;
        deger1_i = a;
        deger2_i = b;
        basla_i  = 1'b1;
        @(posedge clk_i);
        #1;
        basla_i  = 1'b0;
        deger1_i = $urandom;
        deger2_i = $urandom;
        islem_i  = 2'($urandom);
        lat = -1;
        r = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_i);
            if (n == 1) chk({ad, " busy"}, {31'b0, mesgul_o}, 32'd1);
            if (gecerli_o) begin
                lat = n;
                r = sonuc_o;
                break;
            end
        end
        chk({ad, " result"}, r, exp_r);
        chk({ad, " latency"}, lat, exp_lat);
        @(negedge clk_i);
        chk({ad, " pulse end"}, {30'b0, gecerli_o, mesgul_o}, 32'd0);
        chk({ad, " hold"}, sonuc_o, exp_r);
    endtask

    initial begin
        int seen;
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] ea;
        logic [31:0] eb;

        vek[0]  = '{2'b01, 32'd182, 32'd95, 32'd1, 35};
        vek[1]  = '{2'b11, 32'd182, 32'd95, 32'd87, 35};
        vek[2]  = '{2'b00, -32'sd182, 32'd95, 32'hFFFF_FFFF, 35};
        vek[3]  = '{2'b10, -32'sd182, 32'd95, -32'sd87, 35};
        vek[4]  = '{2'b10, 32'd182, -32'sd95, 32'd87, 35};
        vek[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35};
        vek[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35};
        vek[7]  = '{2'b01, 32'd87, 32'd0, 32'hFFFF_FFFF, 2};
        vek[8]  = '{2'b11, 32'd87, 32'd0, 32'd87, 2};
        vek[9]  = '{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2};
        vek[10] = '{2'b10, -32'sd5, 32'd0, -32'sd5, 2};
        vek[11] = '{2'b01, 32'd87, 32'd95, 32'd0, LAT_E};
        vek[12] = '{2'b00, -32'sd7, 32'd2, -32'sd3, 35};
        vek[13] = '{2'b10, -32'sd7, 32'd2, -32'sd1, 35};
        vek[14] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35};
        vek[15] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_E};
        vek[16] = '{2'b10, 32'd3, -32'sd10, 32'd3, LAT_E};

        repeat (3) @(negedge clk_i);
        chk("reset sonuc", sonuc_o, 32'd0);
        chk("reset gecerli", {31'b0, gecerli_o}, 32'd0);
        chk("reset mesgul", {31'b0, mesgul_o}, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 17; i++) begin
            do_op($sformatf("vec%0d", i), vek[i].op, vek[i].a, vek[i].b,
                  vek[i].r, vek[i].lat);
        end

        // reset in the middle of a DIV
        @(negedge clk_i);
        islem_i  = 2'b00;
        deger1_i = 32'd1000;
        deger2_i = 32'd7;
        basla_i  = 1'b1;
        @(posedge clk_i);
        #1;
        basla_i = 1'b0;
        repeat (9) @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrst sonuc", sonuc_o, 32'd0);
        chk("midrst flags", {30'b0, gecerli_o, mesgul_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (gecerli_o) seen++;
        end
        chk("midrst no pulse", seen, 0);
        do_op("after rst", 2'b01, 32'd87, 32'd95, 32'd0, LAT_E);

        // basla held high, operands change every cycle
        @(negedge clk_i);
        islem_i = 2'b01;
        basla_i = 1'b1;
        for (int k = 0; k <= 108; k++) begin
            deger1_i = $urandom | 32'h0001_0000;
            deger2_i = $urandom_range(1000, 1);
            if (k % 36 == 0) begin
                qa.push_back(deger1_i);
                qb.push_back(deger2_i);
            end
            if (k > 0) begin
                chk($sformatf("b2b gecerli k%0d", k), {31'b0, gecerli_o},
                    {31'b0, (k % 36 == 35)});
                if (k % 36 == 35 && qa.size() > 0) begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    chk($sformatf("b2b sonuc k%0d", k), sonuc_o, model(2'b01, ea, eb));
                end
            end
            @(negedge clk_i);
        end
        basla_i = 1'b0;
        repeat (40) @(negedge clk_i);

        // random ops vs model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(5, 0))
                0: b = 32'd0;
                1: b = $urandom_range(16, 1);
                2: b = -32'($urandom_range(16, 1));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            do_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b), model_lat(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
